// File: rtl/mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arb (with bw_mult)
// Purpose  : Round-robin sharing of one signed Baugh-Wooley multiplier among
//            NREQ requesters, two-stage pipeline with in-order responses.
// Revision : 1.0 - initial release
// ============================================================================

module bw_mult #(
   parameter int N = 16
) (
   input  logic [N-1:0]   i_a,
   input  logic [N-1:0]   i_b,
   output logic [2*N-1:0] o_p
);
   // Sign-row/sign-column terms are NANDed; the constant folds in their bias.
   localparam logic [2*N-1:0] c_BW_CORR = {1'b1, {(N-2){1'b0}}, 1'b1, {N{1'b0}}};

   logic [N-1:0]   w_pp [N];
   logic [2*N-1:0] w_sum;

   genvar gi, gj;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         for (gj = 0; gj < N; gj++) begin : g_col
            if ((gi == N-1) != (gj == N-1)) begin : g_inv
               assign w_pp[gi][gj] = ~(i_a[gj] & i_b[gi]);
            end else begin : g_pos
               assign w_pp[gi][gj] = i_a[gj] & i_b[gi];
            end
         end
      end
   endgenerate

   always_comb begin
      w_sum = c_BW_CORR;
      for (int i = 0; i < N; i++) begin
         w_sum = w_sum + ({{N{1'b0}}, w_pp[i]} << i);
      end
   end

   assign o_p = w_sum;
endmodule

module mult_share_arb #(
   parameter int N    = 16,
   parameter int NREQ = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           i_req_valid,
   output logic [NREQ-1:0]           o_req_ready,
   input  logic [NREQ*N-1:0]         i_req_a,
   input  logic [NREQ*N-1:0]         i_req_b,
   output logic                      o_rsp_valid,
   input  logic                      i_rsp_ready,
   output logic [$clog2(NREQ)-1:0]   o_rsp_id,
   output logic [2*N-1:0]            o_rsp_p
);
   localparam int IDW = $clog2(NREQ);

   logic           r_s1_v;
   logic [N-1:0]   r_s1_a;
   logic [N-1:0]   r_s1_b;
   logic [IDW-1:0] r_s1_id;
   logic           r_s2_v;
   logic [2*N-1:0] r_s2_p;
   logic [IDW-1:0] r_s2_id;
   logic [IDW-1:0] r_ptr;

   logic           w_s2_load;
   logic           w_s1_free;
   logic           w_any;
   logic           w_xfer;
   logic           w_found;
   int             w_idx;
   logic [IDW-1:0] w_grant;
   logic [N-1:0]   w_ga;
   logic [N-1:0]   w_gb;
   logic [2*N-1:0] w_prod;

   assign w_s2_load = r_s1_v && (!r_s2_v || i_rsp_ready);
   assign w_s1_free = !r_s1_v || w_s2_load;
   assign w_any     = |i_req_valid;
   // Ready must read zero for the whole time reset is held, not just after it.
   assign w_xfer    = w_any && w_s1_free && !rst;

   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = (int'(r_ptr) + k) % NREQ;
         if (!w_found && i_req_valid[w_idx]) begin
            w_found = 1'b1;
            w_grant = IDW'(w_idx);
         end
      end
   end

   always_comb begin
      w_ga        = '0;
      w_gb        = '0;
      o_req_ready = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (int'(w_grant) == k) begin
            w_ga = i_req_a[k*N +: N];
            w_gb = i_req_b[k*N +: N];
         end
      end
      if (w_xfer) begin
         o_req_ready[w_grant] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_v  <= 1'b0;
         r_s1_a  <= '0;
         r_s1_b  <= '0;
         r_s1_id <= '0;
         r_ptr   <= IDW'(NREQ-1);
      end else if (w_xfer) begin
         r_s1_v  <= 1'b1;
         r_s1_a  <= w_ga;
         r_s1_b  <= w_gb;
         r_s1_id <= w_grant;
         r_ptr   <= w_grant;
      end else if (w_s2_load) begin
         r_s1_v  <= 1'b0;
      end
   end

   bw_mult #(.N(N)) u_mult (
      .i_a (r_s1_a),
      .i_b (r_s1_b),
      .o_p (w_prod)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_v  <= 1'b0;
         r_s2_p  <= '0;
         r_s2_id <= '0;
      end else if (w_s2_load) begin
         r_s2_v  <= 1'b1;
         r_s2_p  <= w_prod;
         r_s2_id <= r_s1_id;
      end else if (r_s2_v && i_rsp_ready) begin
         r_s2_v  <= 1'b0;
      end
   end

   assign o_rsp_valid = r_s2_v;
   assign o_rsp_p     = r_s2_p;
   assign o_rsp_id    = r_s2_id;
endmodule

`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arb
// Purpose  : Directed and random checks of mult_share_arb with a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_mult_share_arb;
   localparam int N    = 16;
   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [1:0]        rsp_id;
   logic [2*N-1:0]    rsp_p;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } vec_t;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] p;
   } exp_t;

   vec_t        vecs[8];
   exp_t        sb[$];
   exp_t        mon_e;
   logic        hold_v = 1'b0;
   logic [1:0]  hold_id;
   logic [31:0] hold_p;
   logic [3:0]  taken;

   mult_share_arb #(.N(N), .NREQ(NREQ)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_id    (rsp_id),
      .o_rsp_p     (rsp_p)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] p;
      p = $signed(a) * $signed(b);
      return p;
   endfunction

   // Mid-cycle monitor: records accepted pairs and retires handshaken products.
   always @(negedge clk) begin
      if (!rst) begin
         chk("ready_onehot", {63'd0, $onehot0(req_ready) && ((req_ready & ~req_valid) == 4'b0)}, 64'd1);
         if (hold_v) begin
            chk("rsp_stable", {rsp_valid, rsp_id, rsp_p}, {1'b1, hold_id, hold_p});
         end
         hold_v  = rsp_valid && !rsp_ready;
         hold_id = rsp_id;
         hold_p  = rsp_p;
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got id=%0d p=%0h expected no response", rsp_id, rsp_p);
            end else begin
               mon_e = sb.pop_front();
               chk("rsp_id", rsp_id, mon_e.id);
               chk("rsp_p", rsp_p, mon_e.p);
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               mon_e.id = 2'(i);
               mon_e.p  = ref_mul(req_a[i*N +: N], req_b[i*N +: N]);
               sb.push_back(mon_e);
            end
         end
      end
   end

   task automatic do_reset();
      req_valid = '0;
      rsp_ready = 1'b1;
      rst       = 1'b1;
      sb.delete();
      hold_v    = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drain_and_check(input string name);
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk(name, sb.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{16'hFFFD, 16'h0005, 32'hFFFFFFF1};
      vecs[1] = '{16'h8000, 16'h8000, 32'h40000000};
      vecs[2] = '{16'h8000, 16'h7FFF, 32'hC0008000};
      vecs[3] = '{16'h0000, 16'h8000, 32'h00000000};
      vecs[4] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
      vecs[6] = '{16'h8000, 16'h0001, 32'hFFFF8000};
      vecs[7] = '{16'h1234, 16'h0010, 32'h00012340};

      // Reset state with all requesters asking.
      rst       = 1'b1;
      req_valid = 4'hF;
      req_a     = {4{16'h1111}};
      req_b     = {4{16'h2222}};
      rsp_ready = 1'b1;
      #3;
      chk("rst_ready", req_ready, 4'b0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_p", rsp_p, 0);
      chk("rst_rsp_id", rsp_id, 0);
      @(posedge clk); #1;
      chk("rst_ready_held", req_ready, 4'b0);
      chk("rst_rsp_valid_held", rsp_valid, 0);
      req_valid = '0;
      rst       = 1'b0;

      // Single requests from requester 2, latency and corner operands.
      for (int v = 0; v < 8; v++) begin
         req_valid          = 4'b0100;
         req_a[2*N +: N]    = vecs[v].a;
         req_b[2*N +: N]    = vecs[v].b;
         #1 chk("single_ready", req_ready, 4'b0100);
         @(posedge clk); #1;
         req_valid = '0;
         chk("single_lat1", rsp_valid, 0);
         @(posedge clk); #1;
         chk("single_valid", rsp_valid, 1);
         chk("single_id", rsp_id, 2);
         chk("single_p", rsp_p, vecs[v].p);
         @(posedge clk); #1;
         chk("single_drain", rsp_valid, 0);
      end

      // Fairness: all four hold valid.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*N +: N] = 16'(i + 1);
         req_b[i*N +: N] = 16'hFF00 + 16'(i);
      end
      req_valid = 4'hF;
      for (int c = 0; c < 12; c++) begin
         #1 chk("fair_grant", req_ready, 4'b0001 << (c % 4));
         if (c >= 2) begin
            chk("fair_rsp_valid", rsp_valid, 1);
            chk("fair_rsp_id", rsp_id, (c - 2) % 4);
         end
         @(posedge clk); #1;
      end
      drain_and_check("fair_sb_empty");

      // Backpressure: requester 1 streams with consumer stalled.
      do_reset();
      rsp_ready = 1'b0;
      begin
         int k;
         k = 0;
         req_valid       = 4'b0010;
         req_a[1*N +: N] = 16'd3;
         req_b[1*N +: N] = 16'hFFF0;
         for (int c = 0; c < 6; c++) begin
            #1 chk("bp_ready", req_ready, (c < 2) ? 4'b0010 : 4'b0000);
            if (c >= 2) begin
               chk("bp_valid", rsp_valid, 1);
               chk("bp_hold_p", rsp_p, 32'hFFFFFFD0);
            end
            taken = req_valid & req_ready;
            @(posedge clk); #1;
            if (taken[1]) begin
               k++;
               req_a[1*N +: N] = 16'(3 + k);
            end
         end
         rsp_ready = 1'b1;
         repeat (4) begin
            #1 taken = req_valid & req_ready;
            @(posedge clk); #1;
            if (taken[1]) begin
               k++;
               req_a[1*N +: N] = 16'(3 + k);
            end
         end
      end
      drain_and_check("bp_sb_empty");

      // Mixed: ptr=0, requesters 0 and 3 -> 3 then 0.
      do_reset();
      req_valid       = 4'b0001;
      req_a[0*N +: N] = 16'd7;
      req_b[0*N +: N] = 16'd6;
      #1 chk("mix_first0", req_ready, 4'b0001);
      @(posedge clk); #1;
      req_valid       = 4'b1001;
      req_a[0*N +: N] = 16'hFFF9;
      req_a[3*N +: N] = 16'd100;
      req_b[3*N +: N] = 16'hFF9C;
      #1 chk("mix_grant3", req_ready, 4'b1000);
      @(posedge clk); #1;
      req_valid = 4'b0001;
      #1 chk("mix_grant0", req_ready, 4'b0001);
      @(posedge clk); #1;
      drain_and_check("mix_sb_empty");

      // Consumer toggling every cycle with all requesters busy.
      req_valid = 4'hF;
      for (int c = 0; c < 24; c++) begin
         rsp_ready = c[0];
         #1 taken = req_valid & req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (taken[i]) begin
               req_a[i*N +: N] = 16'($urandom);
               req_b[i*N +: N] = 16'($urandom);
            end
         end
      end
      drain_and_check("toggle_sb_empty");

      // Random traffic against the reference multiply.
      for (int c = 0; c < 12000; c++) begin
         rsp_ready = ($urandom_range(3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) begin
               req_valid[i]    = 1'($urandom_range(1));
               req_a[i*N +: N] = 16'($urandom);
               req_b[i*N +: N] = 16'($urandom);
            end
         end
         #1 taken = req_valid & req_ready;
         @(posedge clk); #1;
         req_valid = req_valid & ~taken;
      end
      drain_and_check("rand_sb_empty");

      // Reset with both stages full.
      do_reset();
      rsp_ready       = 1'b0;
      req_valid       = 4'b0010;
      req_a[1*N +: N] = 16'd9;
      req_b[1*N +: N] = 16'd9;
      @(posedge clk); #1;
      req_a[1*N +: N] = 16'd10;
      @(posedge clk); #1;
      chk("midrst_full_valid", rsp_valid, 1);
      chk("midrst_full_ready", req_ready, 4'b0);
      #2;
      rst    = 1'b1;
      sb.delete();
      hold_v = 1'b0;
      #1;
      chk("midrst_async_valid", rsp_valid, 0);
      chk("midrst_async_p", rsp_p, 0);
      chk("midrst_ready", req_ready, 4'b0);
      @(posedge clk); #1;
      rst       = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      #1 chk("midrst_no_stale0", rsp_valid, 0);
      @(posedge clk); #1;
      chk("midrst_no_stale1", rsp_valid, 0);
      req_valid       = 4'b1001;
      req_a[0*N +: N] = 16'd2;
      req_b[0*N +: N] = 16'd21;
      #1 chk("midrst_first_grant", req_ready, 4'b0001);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      chk("midrst_rsp_valid", rsp_valid, 1);
      chk("midrst_rsp_p", rsp_p, 32'd42);
      drain_and_check("midrst_sb_empty");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
